// File: rtl/vga_ball_motion_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// vga_ball_motion_ctrl_pkg
// Shared definitions for the vga_ball motion controller:
//   - vga_ball register map (addresses written by the controller)
//   - default active-area dimensions and velocity width
//   - controller FSM state type
//   - clamp_pos(): forces a loaded coordinate into [r, max-1-r]
// ----------------------------------------------------------------------------
package vga_ball_motion_ctrl_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned VEL_W_DEF    = 4;

    // vga_ball register indices
    localparam logic [2:0] REG_RADIUS = 3'd0;
    localparam logic [2:0] REG_BG_G   = 3'd1;
    localparam logic [2:0] REG_BG_B   = 3'd2;
    localparam logic [2:0] REG_X_LO   = 3'd3;
    localparam logic [2:0] REG_X_HI   = 3'd4;
    localparam logic [2:0] REG_Y_LO   = 3'd5;
    localparam logic [2:0] REG_Y_HI   = 3'd6;

    typedef enum logic [2:0] {
        StIdle,
        StUpdate,
        StWrXLo,
        StWrXHi,
        StWrYLo,
        StWrYHi,
        StWrRad
    } state_e;

    // Clamp a coordinate so the whole ball lies inside [0, max-1].
    function automatic logic [9:0] clamp_pos(input logic [9:0]  p,
                                             input logic [7:0]  r,
                                             input logic [11:0] max);
        logic [11:0] w_hi;
        w_hi = max - 12'd1 - {4'b0, r};
        if ({2'b0, p} < {4'b0, r}) begin
            return {2'b0, r};
        end else if ({2'b0, p} > w_hi) begin
            return w_hi[9:0];
        end
        return p;
    endfunction

endpackage

// File: rtl/vga_ball_motion_ctrl_if.sv
// ----------------------------------------------------------------------------
// vga_ball_motion_ctrl_if
// Bundles the software config port (valid/ready) and the vga_ball register
// write bus. The controller uses the master modport; the peer (software side
// plus vga_ball) uses the slave modport.
//   cfg_valid/cfg_ready, cfg_x, cfg_y, cfg_dx, cfg_dy, cfg_radius : config word
//   chipselect, write, address, writedata                        : vga_ball bus
// ----------------------------------------------------------------------------
interface vga_ball_motion_ctrl_if #(
    parameter int unsigned VEL_W = 4
);
    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [9:0]              cfg_x;
    logic [9:0]              cfg_y;
    logic signed [VEL_W-1:0] cfg_dx;
    logic signed [VEL_W-1:0] cfg_dy;
    logic [7:0]              cfg_radius;

    logic                    chipselect;
    logic                    write;
    logic [2:0]              address;
    logic [7:0]              writedata;

    modport master (
        input  cfg_valid, cfg_x, cfg_y, cfg_dx, cfg_dy, cfg_radius,
        output cfg_ready, chipselect, write, address, writedata
    );

    modport slave (
        output cfg_valid, cfg_x, cfg_y, cfg_dx, cfg_dy, cfg_radius,
        input  cfg_ready, chipselect, write, address, writedata
    );

endinterface

// File: rtl/vga_ball_motion_ctrl_bounce_axis.sv
// ----------------------------------------------------------------------------
// vga_ball_motion_ctrl_bounce_axis
// Combinational one-axis position step with edge bounce.
//   i_p, i_d, i_r : current position, signed velocity, radius
//   o_p, o_d      : next position and velocity (velocity negated on bounce)
// The step is evaluated in 12-bit signed arithmetic so a negative excursion
// past the low edge is detected correctly.
// ----------------------------------------------------------------------------
module vga_ball_motion_ctrl_bounce_axis #(
    parameter int unsigned MAX   = 640,
    parameter int unsigned VEL_W = 4
) (
    input  logic [9:0]              i_p,
    input  logic signed [VEL_W-1:0] i_d,
    input  logic [7:0]              i_r,
    output logic [9:0]              o_p,
    output logic signed [VEL_W-1:0] o_d
);
    localparam logic signed [11:0] LpMaxM1 = 12'(MAX - 1);

    logic signed [11:0] w_pn;
    logic signed [11:0] w_r;
    logic signed [11:0] w_d;

    assign w_d  = {{(12-VEL_W){i_d[VEL_W-1]}}, i_d};
    assign w_r  = $signed({4'b0, i_r});
    assign w_pn = $signed({2'b00, i_p}) + w_d;

    always_comb begin
        o_p = w_pn[9:0];
        o_d = i_d;
        if (w_pn + w_r > LpMaxM1) begin
            o_p = 10'(LpMaxM1 - w_r);
            o_d = -i_d;
        end else if (w_pn < w_r) begin
            o_p = i_r[7:0] == 8'd0 ? 10'd0 : {2'b00, i_r};
            o_d = -i_d;
        end
    end

endmodule

// File: rtl/vga_ball_motion_ctrl.sv
// ----------------------------------------------------------------------------
// vga_ball_motion_ctrl
// Frame-synchronous bus master animating the vga_ball peripheral. On each
// falling edge of vga_vs (while enabled) it steps the ball position, then
// writes x/y low/high halves and, if changed, the radius to vga_ball.
//   i_clk, i_reset_n : clock, async active-low reset
//   i_enable         : animate on frame ticks when high
//   i_vga_vs         : VGA vsync from vga_ball (active low)
//   io_bus           : config port + vga_ball write bus (master modport)
//   o_busy           : high from UPDATE through the last write
//   o_overrun_cnt    : saturating count of ticks seen while busy
// ----------------------------------------------------------------------------
module vga_ball_motion_ctrl
    import vga_ball_motion_ctrl_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned VEL_W    = VEL_W_DEF,
    parameter int unsigned INIT_X   = 320,
    parameter int unsigned INIT_Y   = 240,
    parameter int unsigned INIT_R   = 16,
    parameter int          INIT_DX  = 1,
    parameter int          INIT_DY  = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_enable,
    input  logic                  i_vga_vs,
    vga_ball_motion_ctrl_if.master io_bus,
    output logic                  o_busy,
    output logic [7:0]            o_overrun_cnt
);
    // Most negative velocity is not negatable; it loads as its symmetric value.
    localparam logic signed [VEL_W-1:0] LpVelMin = {1'b1, {(VEL_W-1){1'b0}}};
    localparam logic signed [VEL_W-1:0] LpVelSat = {1'b1, {(VEL_W-2){1'b0}}, 1'b1};

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic                    r_vs_q;
    logic                    r_started;
    logic [9:0]              r_x, r_y;
    logic signed [VEL_W-1:0] r_dx, r_dy;
    logic [7:0]              r_r;
    logic                    r_rad_dirty;
    logic [2:0]              r_addr;
    logic [7:0]              r_wdata;
    logic [7:0]              r_ovr;

    logic                    w_tick_en;
    logic                    w_cfg_ready;
    logic                    w_cfg_acc;
    logic                    w_write;
    logic [2:0]              w_addr;
    logic [7:0]              w_wdata;
    logic [9:0]              w_x_nxt, w_y_nxt;
    logic signed [VEL_W-1:0] w_dx_nxt, w_dy_nxt;
    logic signed [VEL_W-1:0] w_cfg_dx, w_cfg_dy;

    assign w_tick_en   = r_vs_q & ~i_vga_vs & i_enable;
    assign w_cfg_ready = (r_state == StIdle) & r_started;
    assign w_cfg_acc   = io_bus.cfg_valid & w_cfg_ready;
    assign w_cfg_dx    = (io_bus.cfg_dx == LpVelMin) ? LpVelSat : io_bus.cfg_dx;
    assign w_cfg_dy    = (io_bus.cfg_dy == LpVelMin) ? LpVelSat : io_bus.cfg_dy;

    vga_ball_motion_ctrl_bounce_axis #(.MAX(H_ACTIVE), .VEL_W(VEL_W)) u_bounce_x (
        .i_p(r_x), .i_d(r_dx), .i_r(r_r), .o_p(w_x_nxt), .o_d(w_dx_nxt)
    );

    vga_ball_motion_ctrl_bounce_axis #(.MAX(V_ACTIVE), .VEL_W(VEL_W)) u_bounce_y (
        .i_p(r_y), .i_d(r_dy), .i_r(r_r), .o_p(w_y_nxt), .o_d(w_dy_nxt)
    );

    // Next state and bus outputs; address/writedata hold between writes.
    always_comb begin
        w_state_nxt = r_state;
        w_write     = 1'b0;
        w_addr      = r_addr;
        w_wdata     = r_wdata;
        unique case (r_state)
            StIdle:   if (w_tick_en) w_state_nxt = StUpdate;
            StUpdate: w_state_nxt = StWrXLo;
            StWrXLo: begin
                w_write = 1'b1; w_addr = REG_X_LO; w_wdata = {3'b0, r_x[4:0]};
                w_state_nxt = StWrXHi;
            end
            StWrXHi: begin
                w_write = 1'b1; w_addr = REG_X_HI; w_wdata = {3'b0, r_x[9:5]};
                w_state_nxt = StWrYLo;
            end
            StWrYLo: begin
                w_write = 1'b1; w_addr = REG_Y_LO; w_wdata = {3'b0, r_y[4:0]};
                w_state_nxt = StWrYHi;
            end
            StWrYHi: begin
                w_write = 1'b1; w_addr = REG_Y_HI; w_wdata = {3'b0, r_y[9:5]};
                w_state_nxt = r_rad_dirty ? StWrRad : StIdle;
            end
            StWrRad: begin
                w_write = 1'b1; w_addr = REG_RADIUS; w_wdata = r_r;
                w_state_nxt = StIdle;
            end
            default:  w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_vs_q      <= 1'b1;
            r_started   <= 1'b0;
            r_x         <= 10'(INIT_X);
            r_y         <= 10'(INIT_Y);
            r_dx        <= VEL_W'(INIT_DX);
            r_dy        <= VEL_W'(INIT_DY);
            r_r         <= 8'(INIT_R);
            r_rad_dirty <= 1'b1;
            r_addr      <= 3'd0;
            r_wdata     <= 8'd0;
            r_ovr       <= 8'd0;
        end else begin
            r_vs_q    <= i_vga_vs;
            r_started <= 1'b1;
            r_addr    <= w_addr;
            r_wdata   <= w_wdata;
            if (w_cfg_acc) begin
                r_x         <= clamp_pos(io_bus.cfg_x, io_bus.cfg_radius, 12'(H_ACTIVE));
                r_y         <= clamp_pos(io_bus.cfg_y, io_bus.cfg_radius, 12'(V_ACTIVE));
                r_dx        <= w_cfg_dx;
                r_dy        <= w_cfg_dy;
                r_r         <= io_bus.cfg_radius;
                r_rad_dirty <= 1'b1;
            end else if (r_state == StUpdate) begin
                r_x  <= w_x_nxt;
                r_y  <= w_y_nxt;
                r_dx <= w_dx_nxt;
                r_dy <= w_dy_nxt;
            end
            if (r_state == StWrRad) r_rad_dirty <= 1'b0;
            if (w_tick_en && (r_state != StIdle) && (r_ovr != 8'hFF)) r_ovr <= r_ovr + 8'd1;
        end
    end

    assign io_bus.cfg_ready  = w_cfg_ready;
    assign io_bus.write      = w_write;
    assign io_bus.chipselect = w_write;
    assign io_bus.address    = w_addr;
    assign io_bus.writedata  = w_wdata;
    assign o_busy            = (r_state != StIdle);
    assign o_overrun_cnt     = r_ovr;

endmodule

// File: tb/tb_vga_ball_motion_ctrl.sv
// ----------------------------------------------------------------------------
// tb_vga_ball_motion_ctrl
// Scoreboard bench: stimulus tasks update a behavioural ball model and push
// the expected vga_ball writes into a queue; a monitor on the falling clock
// edge pops and compares every write the controller issues.
// ----------------------------------------------------------------------------
module tb_vga_ball_motion_ctrl;
    localparam int HA = 640;
    localparam int VA = 480;

    typedef struct {
        int a;
        int d;
    } wr_t;

    logic clk = 1'b0;
    logic reset_n;
    logic en;
    logic vs;
    logic busy;
    logic [7:0] ovr;

    always #10 clk = ~clk;

    vga_ball_motion_ctrl_if #(.VEL_W(4)) bus ();

    vga_ball_motion_ctrl dut (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_enable     (en),
        .i_vga_vs     (vs),
        .io_bus       (bus),
        .o_busy       (busy),
        .o_overrun_cnt(ovr)
    );

    int  n_checks = 0;
    int  n_pass   = 0;
    wr_t exp_q[$];
    int  last_a, last_d;

    // Reference ball state
    int  mx, my, mdx, mdy, mr, exp_ovr;
    bit  mdirty;

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endfunction

    function automatic void model_reset();
        mx = 320; my = 240; mdx = 1; mdy = 1; mr = 16; mdirty = 1'b1; exp_ovr = 0;
        exp_q.delete();
    endfunction

    function automatic int clampv(input int p, input int r, input int maxv);
        if (p < r) return r;
        if (p > maxv - 1 - r) return maxv - 1 - r;
        return p;
    endfunction

    function automatic void model_cfg(input int x, input int y, input int dx, input int dy,
                                      input int r);
        mr  = r;
        mx  = clampv(x, r, HA);
        my  = clampv(y, r, VA);
        mdx = (dx == -8) ? -7 : dx;
        mdy = (dy == -8) ? -7 : dy;
        mdirty = 1'b1;
    endfunction

    function automatic void step_axis(inout int p, inout int d, input int r, input int maxv);
        int pn;
        pn = p + d;
        if (pn + r > maxv - 1) begin
            p = maxv - 1 - r; d = -d;
        end else if (pn < r) begin
            p = r; d = -d;
        end else begin
            p = pn;
        end
    endfunction

    function automatic void push(input int a, input int d);
        wr_t e;
        e.a = a; e.d = d;
        exp_q.push_back(e);
    endfunction

    function automatic void model_frame();
        step_axis(mx, mdx, mr, HA);
        step_axis(my, mdy, mr, VA);
        push(3, mx % 32); push(4, mx / 32);
        push(5, my % 32); push(6, my / 32);
        if (mdirty) push(0, mr);
        mdirty = 1'b0;
    endfunction

    // Monitor: every write must match the head of the expected queue.
    always @(negedge clk) begin
        wr_t e;
        if (bus.write || bus.chipselect) chk("cs_eq_write", bus.chipselect, bus.write);
        if (bus.write) begin
            chk("write_expected", (exp_q.size() > 0) ? 1 : 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", bus.address, e.a);
                chk("wr_data", bus.writedata, e.d);
                last_a = e.a; last_d = e.d;
            end
        end
    end

    // Called on the negedge just after the tick edge; counts busy cycles.
    task automatic wait_seq(input int exp_busy);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            cnt++;
            @(negedge clk);
        end
        chk("busy_cycles", cnt, exp_busy);
        chk("writes_outstanding", exp_q.size(), 0);
        if (exp_busy > 0) begin
            chk("addr_hold", bus.address, last_a);
            chk("data_hold", bus.writedata, last_d);
        end
    endtask

    task automatic do_frame();
        int exp_busy;
        @(negedge clk);
        vs = 1'b0;
        if (en) begin
            exp_busy = mdirty ? 6 : 5;
            model_frame();
        end else begin
            exp_busy = 0;
        end
        @(negedge clk);
        vs = 1'b1;
        wait_seq(exp_busy);
    endtask

    task automatic send_cfg(input int x, input int y, input int dx, input int dy, input int r);
        int ok;
        int dxv, dyv;
        dxv = dx; dyv = dy;
        @(negedge clk);
        bus.cfg_x = 10'(x); bus.cfg_y = 10'(y);
        bus.cfg_dx = dxv[3:0]; bus.cfg_dy = dyv[3:0];
        bus.cfg_radius = 8'(r);
        bus.cfg_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.cfg_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("cfg_ready_wait", ok, 1);
        if (ok != 0) model_cfg(x, y, dx, dy, r);
        @(negedge clk);
        bus.cfg_valid = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; en = 1'b1; vs = 1'b1;
        bus.cfg_valid = 1'b0; bus.cfg_x = '0; bus.cfg_y = '0;
        bus.cfg_dx = '0; bus.cfg_dy = '0; bus.cfg_radius = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_write", bus.write, 0);
        chk("rst_cs", bus.chipselect, 0);
        chk("rst_addr", bus.address, 0);
        chk("rst_wdata", bus.writedata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_cfg_ready", bus.cfg_ready, 0);
        reset_n = 1'b1;
        #1 chk("cfg_ready_pre_clk", bus.cfg_ready, 0);
        @(negedge clk);
        chk("cfg_ready_post_clk", bus.cfg_ready, 1);

        // Default frame: x=321 y=241 plus radius
        do_frame();
        // Right-edge bounce, then a frame without radius
        send_cfg(622, 240, 3, 1, 16);
        do_frame();
        do_frame();
        // Left-edge bounce, velocity saturation
        send_cfg(17, 240, -3, 1, 16);
        do_frame();
        send_cfg(300, 240, -8, -8, 16);
        do_frame();
        do_frame();
        // Corner bounce on both axes
        send_cfg(620, 460, 5, 5, 19);
        do_frame();

        // Overrun: second tick two cycles into the sequence
        @(negedge clk); vs = 1'b0; model_frame();
        @(negedge clk); vs = 1'b1;
        @(negedge clk); vs = 1'b0; exp_ovr++;
        @(negedge clk); vs = 1'b1;
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        chk("ovr_idle", busy, 0);
        chk("ovr_writes_outstanding", exp_q.size(), 0);
        chk("ovr_cnt", ovr, exp_ovr);
        repeat (3) @(negedge clk);
        chk("ovr_no_restart", busy, 0);

        // Config and tick in the same idle cycle
        @(negedge clk);
        bus.cfg_x = 10'd100; bus.cfg_y = 10'd50; bus.cfg_dx = 4'sd2; bus.cfg_dy = -4'sd1;
        bus.cfg_radius = 8'd20; bus.cfg_valid = 1'b1; vs = 1'b0;
        chk("simul_cfg_ready", bus.cfg_ready, 1);
        model_cfg(100, 50, 2, -1, 20);
        model_frame();
        @(negedge clk);
        bus.cfg_valid = 1'b0; vs = 1'b1;
        chk("simul_cfg_ready_busy", bus.cfg_ready, 0);
        wait_seq(6);

        // Reset during WR_XHI
        @(negedge clk); vs = 1'b0; model_frame();
        @(negedge clk); vs = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1 chk("rst_mid_write", bus.write, 0);
        chk("rst_mid_cs", bus.chipselect, 0);
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ovr", ovr, 0);
        do_frame();

        // Ticks ignored while disabled
        en = 1'b0;
        do_frame();
        en = 1'b1;

        // Randomized frames and configs
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                send_cfg(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                         int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8,
                         int'($urandom_range(0, 120)));
            end
            en = ($urandom_range(0, 7) != 0);
            do_frame();
            en = 1'b1;
        end

        chk("final_ovr", ovr, exp_ovr);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
